// File: rtl/serial_frame_tx_pkg.sv
// Shared types and line levels for the serial frame transmitter.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package serial_frame_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  localparam logic LINE_IDLE = 1'b1;
  localparam logic START_LVL = 1'b0;
  localparam logic STOP_LVL  = 1'b1;

endpackage

// File: rtl/serial_frame_tx_if.sv
// Word handshake plus serial line outputs of the frame transmitter.
// Latency: n/a (signal bundle only).
// Backpressure: tx_valid/tx_ready; the word moves on an edge where both are 1.
// Signals: tx_valid, tx_data (source -> tx), tx_ready, tx_line, tx_oe, busy, done (tx -> source).
interface serial_frame_tx_if #(
  parameter int DATA_W = 8
);
  logic              tx_valid;
  logic [DATA_W-1:0] tx_data;
  logic              tx_ready;
  logic              tx_line;
  logic              tx_oe;
  logic              busy;
  logic              done;

  modport master (
    output tx_valid, tx_data,
    input  tx_ready, tx_line, tx_oe, busy, done
  );

  modport slave (
    input  tx_valid, tx_data,
    output tx_ready, tx_line, tx_oe, busy, done
  );
endinterface

// File: rtl/serial_frame_tx_bit_timer.sv
// Bit-period timer: counts 0..BIT_CYC-1 while run is high, bit_tick on the last count.
// Latency: bit_tick is combinational from the count; count advances each edge.
// Backpressure: none; run=0 or rst=0 holds the count at zero.
// Ports: clk, rst (sync active-low), run, bit_tick.
module bit_timer #(
  parameter int BIT_CYC = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  output logic bit_tick
);
  // Keep at least one counter bit so BIT_CYC=1 still elaborates; the count
  // then never leaves zero and bit_tick is permanently high.
  localparam int CW = (BIT_CYC > 1) ? $clog2(BIT_CYC) : 1;
  localparam logic [CW-1:0] LAST = CW'(BIT_CYC - 1);

  logic [CW-1:0] cnt;

  assign bit_tick = (cnt == LAST);

  always_ff @(posedge clk) begin
    if (!rst || !run || bit_tick) cnt <= '0;
    else                          cnt <= cnt + CW'(1);
  end
endmodule

// File: rtl/serial_frame_tx.sv
// Serial frame transmitter: start bit, DATA_W data bits LSB-first, optional even parity, stop bit.
// Latency: start bit on the line the cycle after acceptance; done pulses the cycle after the stop bit.
// Backpressure: tx_ready only in IDLE (incl. the done cycle); offers while busy are ignored.
// Ports: clk, rst (sync active-low), bus (slave modport: tx_valid/tx_data in; tx_ready/tx_line/tx_oe/busy/done out).
// Build option: define TX_PARITY_EN to insert the even-parity bit between data and stop.
module serial_frame_tx
  import serial_frame_pkg::*;
#(
  parameter int DATA_W  = 8,
  parameter int BIT_CYC = 4
) (
  input  logic              clk,
  input  logic              rst,
  serial_frame_tx_if.slave  bus
);
  localparam int CNT_W = $clog2(DATA_W + 1);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

  state_t            state, state_nxt;
  logic [DATA_W-1:0] shreg, shreg_nxt;
  logic [CNT_W-1:0]  bit_cnt, bit_cnt_nxt;
  logic              line_nxt, active_nxt, done_nxt;
  logic              bit_tick, accept;
`ifdef TX_PARITY_EN
  logic              par_acc, par_nxt;
`endif

  assign bus.tx_ready = (state == IDLE) && rst;
  assign accept       = bus.tx_valid && bus.tx_ready;

  bit_timer #(.BIT_CYC(BIT_CYC)) u_bit_timer (
    .clk      (clk),
    .rst      (rst),
    .run      (state != IDLE),
    .bit_tick (bit_tick)
  );

  always_comb begin
    state_nxt   = state;
    shreg_nxt   = shreg;
    bit_cnt_nxt = bit_cnt;
    done_nxt    = 1'b0;
`ifdef TX_PARITY_EN
    par_nxt     = par_acc;
`endif
    case (state)
      IDLE: begin
        if (accept) begin
          state_nxt   = START;
          shreg_nxt   = bus.tx_data;
          bit_cnt_nxt = '0;
`ifdef TX_PARITY_EN
          par_nxt     = 1'b0;
`endif
        end
      end
      START: begin
        if (bit_tick) state_nxt = DATA;
      end
      DATA: begin
        if (bit_tick) begin
          shreg_nxt = shreg >> 1;
`ifdef TX_PARITY_EN
          par_nxt   = par_acc ^ shreg[0];
`endif
          if (bit_cnt == LAST_BIT) begin
            bit_cnt_nxt = '0;
`ifdef TX_PARITY_EN
            state_nxt   = PARITY;
`else
            state_nxt   = STOP;
`endif
          end else begin
            bit_cnt_nxt = bit_cnt + CNT_W'(1);
          end
        end
      end
`ifdef TX_PARITY_EN
      PARITY: begin
        if (bit_tick) state_nxt = STOP;
      end
`endif
      STOP: begin
        if (bit_tick) begin
          state_nxt = IDLE;
          done_nxt  = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase

    // Outputs are registered, so derive them from the state being entered.
    line_nxt = LINE_IDLE;
    case (state_nxt)
      START:  line_nxt = START_LVL;
      DATA:   line_nxt = shreg_nxt[0];
`ifdef TX_PARITY_EN
      PARITY: line_nxt = par_nxt;
`endif
      STOP:   line_nxt = STOP_LVL;
      default: line_nxt = LINE_IDLE;
    endcase
    active_nxt = (state_nxt != IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= IDLE;
      shreg       <= '0;
      bit_cnt     <= '0;
      bus.tx_line <= LINE_IDLE;
      bus.tx_oe   <= 1'b0;
      bus.busy    <= 1'b0;
      bus.done    <= 1'b0;
`ifdef TX_PARITY_EN
      par_acc     <= 1'b0;
`endif
    end else begin
      state       <= state_nxt;
      shreg       <= shreg_nxt;
      bit_cnt     <= bit_cnt_nxt;
      bus.tx_line <= line_nxt;
      bus.tx_oe   <= active_nxt;
      bus.busy    <= active_nxt;
      bus.done    <= done_nxt;
`ifdef TX_PARITY_EN
      par_acc     <= par_nxt;
`endif
    end
  end
endmodule

// File: doc/serial_frame_tx.md
Name: serial_frame_tx

Overview:
- Serial frame transmitter: accepts a parallel word over a valid/ready handshake and shifts it out on one line as start bit, data LSB-first, optional even parity, then stop bit.
- It is the transmitting end for the team's serial-frame receiver and sequence-detector FSMs.
- It also provides an output enable, so the line can be driven onto a shared wire through the library's non-inverting tri-state buffer.

Parameters:
- DATA_W, 8, data bits per frame; must be >= 1.
- BIT_CYC, 4, clock cycles each bit is held on the line; must be >= 1.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous active-low reset.
- tx_valid  input  1  a word is offered on tx_data.
- tx_data  input  DATA_W  word to send; sampled only at acceptance.
- tx_ready  output  1  transmitter can accept a word this cycle.
- tx_line  output  1  serial line; idle level 1.
- tx_oe  output  1  line-drive enable; 1 only while a frame is on the line.
- busy  output  1  frame in progress.
- done  output  1  one-cycle pulse when a frame completes.

Behaviour:
- Interface: one clock and synchronous active-low reset, named clk and rst. rst is sampled only on the rising edge of clk.
- Reset (rst=0 at an edge):
  - state=IDLE, tx_line=1, tx_oe=0, busy=0, done=0.
  - Bit timer and bit counter cleared.
  - tx_ready=0 while rst=0.
- Reset mid-frame aborts immediately. No stop bit is sent; the line returns to 1 on the next edge.
- States: IDLE, START, DATA, PARITY, STOP. All outputs are registered except tx_ready.
- tx_ready is combinational: tx_ready = (state==IDLE) && rst.
- Acceptance: tx_valid && tx_ready at an edge.
  - tx_data is loaded into the shift register and the parity accumulator is cleared.
  - The next state is START.
- Latency: tx_line=0 and tx_oe=1 in the first cycle after the acceptance edge.
- Bit timing:
  - The bit timer counts 0..BIT_CYC-1. bit_tick is asserted at count BIT_CYC-1.
  - Each bit occupies exactly BIT_CYC cycles.
- Transitions, each taken on bit_tick:
  - START -> DATA.
  - DATA shifts right after each bit. After DATA_W bits: -> PARITY if TX_PARITY_EN, else -> STOP.
  - PARITY -> STOP.
  - STOP -> IDLE.
- Line levels:
  - START: 0.
  - DATA: shift register bit 0.
  - PARITY: XOR of all data bits (even parity).
  - STOP: 1.
  - IDLE: 1.
- busy and tx_oe are 1 in START, DATA, PARITY and STOP; 0 in IDLE.
- done is 1 for exactly the first IDLE cycle after STOP. It is not asserted after a reset abort.
- Back-to-back: tx_ready is 1 in the done cycle, so a word offered then is accepted. Line gap between frames is one idle cycle.
- tx_valid and tx_data changes while busy are ignored. tx_valid held across frames is not double-counted.
- Frame length from acceptance to done: (DATA_W+2+P)*BIT_CYC cycles, P=1 with parity, else 0. done is in the cycle after the last bit.
- BIT_CYC=1: bit_tick is constantly 1, giving one bit per cycle.
- Bit counter width: $clog2(DATA_W+1).

Optional Feature:
- TX_PARITY_EN defined: the PARITY state is present and an even-parity bit is sent between the data bits and the stop bit.
- TX_PARITY_EN undefined: the PARITY state and parity accumulator are compiled out, and DATA goes directly to STOP.

Decomposition:
- Package serial_frame_pkg:
  - State enum with encodings IDLE=0, START=1, DATA=2, PARITY=3, STOP=4.
  - Constants LINE_IDLE=1, START_LVL=0, STOP_LVL=1.
- Sub-module bit_timer:
  - Parameter BIT_CYC; ports clk, rst, run.
  - Output bit_tick.
  - Counter clears when run=0 or rst=0.

Test Plan (DATA_W=8, BIT_CYC=4, TX_PARITY_EN unless noted):
1. Offer 0xA5 from IDLE -> accepted same cycle. tx_line sequence per 4 cycles: 0, 1,0,1,0,0,1,0,1, parity 0, 1. done pulses 44 cycles after the accept edge. tx_oe high for 44 cycles.
2. Offer 0x07 -> parity bit 1. Rebuild with TX_PARITY_EN undefined, offer 0x07 -> 10 bits, done after 40 cycles.
3. Hold tx_valid=1 with 0x3C then 0xC3 presented at done -> second frame accepted in the done cycle. Exactly one idle-high cycle between stop bit and next start bit.
4. Change tx_data to 0xFF mid-frame while tx_valid=1 -> the transmitted word stays 0xA5 and no extra acceptance occurs.
5. Assert rst=0 during DATA bit 3 -> next cycle tx_line=1, tx_oe=0, busy=0, no done pulse. After rst=1, tx_ready=1 and a fresh frame sends correctly.
6. BIT_CYC=1, offer 0x81 -> 11 consecutive cycles 0,1,0,0,0,0,0,0,1,0,1, then done.
